// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : lc3_mem_pkg                                          |
// | Purpose   : Shared definitions for the LC-3 memory-access stage: |
// |             memory op codes, FSM state encoding, NZP constants   |
// |             and op classification helpers.                       |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
package lc3_mem_pkg;

  localparam logic [2:0] MEM_LD  = 3'd0;
  localparam logic [2:0] MEM_LDR = 3'd1;
  localparam logic [2:0] MEM_LDI = 3'd2;
  localparam logic [2:0] MEM_ST  = 3'd3;
  localparam logic [2:0] MEM_STR = 3'd4;
  localparam logic [2:0] MEM_STI = 3'd5;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Ops whose first access is a read: direct loads plus both pointer chases.
  function automatic logic first_is_read(input logic [2:0] op);
    return (op == MEM_LD) || (op == MEM_LDR) || (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  function automatic logic is_direct_store(input logic [2:0] op);
    return (op == MEM_ST) || (op == MEM_STR);
  endfunction

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/lc3_mem_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : lc3_mem_stage_if                                     |
// | Purpose   : Bundles the upstream request/response signals and    |
// |             the data_mem bus of the memory-access stage.         |
// | Ports     : start/op/ea/st_data   request from execute stage     |
// |             busy/done/err         status back to the sequencer   |
// |             load_data/cc          load result to writeback       |
// |             mem_read/mem_write/mem_addr/mem_wdata/mem_rdata      |
// |                                   data_mem access bus            |
// |             slave  = the stage, master = its environment         |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
interface lc3_mem_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] st_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] load_data;
  logic [2:0]        cc;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  start, op, ea, st_data, mem_rdata,
    output busy, done, err, load_data, cc,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output start, op, ea, st_data, mem_rdata,
    input  busy, done, err, load_data, cc,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface : lc3_mem_stage_if
`default_nettype wire

// File: rtl/lc3_mem_stage_cc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : lc3_cc_gen                                           |
// | Purpose   : Combinational LC-3 condition-code generator; returns |
// |             one-hot {N,Z,P} for a data word.                     |
// | Ports     : value  in  DATA_W  word to classify                  |
// |             nzp    out 3       {N,Z,P}, exactly one bit set      |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module lc3_cc_gen
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] value,
  output logic [2:0]        nzp
);

  always_comb begin
    nzp = CC_P;
    if (value[DATA_W-1])  nzp = CC_N;
    else if (value == '0) nzp = CC_Z;
  end

endmodule : lc3_cc_gen
`default_nettype wire

// File: rtl/lc3_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : lc3_mem_stage                                        |
// | Purpose   : LC-3 memory-access stage. Sequences LD/LDR/LDI/ST/   |
// |             STR/STI against data_mem, chasing the pointer for    |
// |             LDI/STI, and produces load_data plus NZP on loads.   |
// | Ports     : clk   in  clock, all state changes on posedge        |
// |             rst   in  synchronous active-high reset              |
// |             bus   slave modport of lc3_mem_stage_if (request,    |
// |                   status, load result and data_mem bus)          |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module lc3_mem_stage
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  lc3_mem_stage_if.slave   bus
);

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_q;
  logic [2:0]        cc_q;
  logic              err_q;
  logic [2:0]        rdata_nzp;

  // NZP is computed on the word being loaded so cc lands together with load_data.
  lc3_cc_gen #(.DATA_W(DATA_W)) u_cc_gen (
    .value (bus.mem_rdata),
    .nzp   (rdata_nzp)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == RESP);
  assign bus.err       = (state == RESP) && err_q;
  assign bus.load_data = load_q;
  assign bus.cc        = cc_q;

  // Bus strobes are decoded from state and masked by rst so an abort in
  // ACC1/ACC2 never reaches memory during the reset cycle.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ACC1: begin
        bus.mem_addr = addr_q;
        if (first_is_read(op_q)) begin
          bus.mem_read = !rst;
        end
        if (is_direct_store(op_q)) begin
          bus.mem_write = !rst;
          bus.mem_wdata = wdata_q;
        end
      end
      ACC2: begin
        bus.mem_addr = ptr_q;
        if (op_q == MEM_LDI) begin
          bus.mem_read = !rst;
        end
        if (op_q == MEM_STI) begin
          bus.mem_write = !rst;
          bus.mem_wdata = wdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      cc_q    <= CC_Z;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            addr_q  <= bus.ea;
            wdata_q <= bus.st_data;
            state   <= ACC1;
          end
        end
        ACC1: begin
          case (op_q)
            MEM_LD, MEM_LDR: begin
              load_q <= bus.mem_rdata;
              cc_q   <= rdata_nzp;
              state  <= RESP;
            end
            MEM_LDI, MEM_STI: begin
              ptr_q <= bus.mem_rdata[ADDR_W-1:0];
              state <= ACC2;
            end
            MEM_ST, MEM_STR: begin
              state <= RESP;
            end
            default: begin
              err_q <= 1'b1;
              state <= RESP;
            end
          endcase
        end
        ACC2: begin
          if (op_q == MEM_LDI) begin
            load_q <= bus.mem_rdata;
            cc_q   <= rdata_nzp;
          end
          state <= RESP;
        end
        RESP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : lc3_mem_stage
`default_nettype wire

// File: tb/tb_lc3_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : tb_lc3_mem_stage                                     |
// | Purpose   : Self-checking bench for lc3_mem_stage with a         |
// |             behavioural data_mem and a reference model of the    |
// |             LC-3 memory operations.                              |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module tb_lc3_mem_stage;
  import lc3_mem_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lc3_mem_stage_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_stage #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // data_mem: combinational read, write on posedge; backdoor preload and clear.
  logic [15:0] mem [0:65535];
  logic        mem_clr = 1'b1;
  logic        pl_en   = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference state
  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_ld = '0;
  logic [2:0]  exp_cc = 3'b010;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  acc_t acc_log[$];

  always @(negedge clk) begin
    acc_t a;
    if (bus.mem_read || bus.mem_write) begin
      a.rd = bus.mem_read; a.wr = bus.mem_write;
      a.addr = bus.mem_addr; a.wdata = bus.mem_wdata;
      acc_log.push_back(a);
    end
    if (bus.done) done_cnt++;
  end

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one request and measures cycles from the start cycle to done.
  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic e);
    acc_log.delete();
    lat = -1; e = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.ea = a; bus.st_data = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i; e = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
        {bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write});
    end
    n_tests++;
    if (bus.load_data !== 16'h0 || bus.cc !== 3'b010) begin
      n_fail++; $display("FAIL reset_result: got ld=%h cc=%b required ld=0000 cc=010",
        bus.load_data, bus.cc);
    end
    n_tests++;
    if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_bus: got addr=%h wdata=%h required 0000/0000",
        bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, d, p, v;
    logic [2:0]  o;
    logic        e, exp_err;
    int          lat, exp_lat;
    acc_t        exp_q[$];
    acc_t        x;
    for (int i = 0; i < 16; i++)
      preload(16'h3000 | 16'(i), ($urandom_range(0, 1) == 1) ?
              (16'h3000 | 16'($urandom_range(0, 15))) : 16'($urandom));
    preload(16'hFFFF, 16'h3005);
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : (16'h3000 | 16'($urandom_range(0, 15)));
      d = ($urandom_range(0, 1) == 1) ? (16'h3000 | 16'($urandom_range(0, 15))) : 16'($urandom);
      exp_q.delete(); exp_err = 1'b0; exp_lat = 2;
      case (o)
        MEM_LD, MEM_LDR: begin
          x = '{rd: 1'b1, wr: 1'b0, addr: a, wdata: 16'h0}; exp_q.push_back(x);
          v = ref_mem[a]; exp_ld = v; exp_cc = cc_of(v);
        end
        MEM_LDI: begin
          p = ref_mem[a]; v = ref_mem[p];
          x = '{rd: 1'b1, wr: 1'b0, addr: a, wdata: 16'h0}; exp_q.push_back(x);
          x = '{rd: 1'b1, wr: 1'b0, addr: p, wdata: 16'h0}; exp_q.push_back(x);
          exp_ld = v; exp_cc = cc_of(v); exp_lat = 3;
        end
        MEM_ST, MEM_STR: begin
          x = '{rd: 1'b0, wr: 1'b1, addr: a, wdata: d}; exp_q.push_back(x);
          ref_mem[a] = d;
        end
        MEM_STI: begin
          p = ref_mem[a];
          x = '{rd: 1'b1, wr: 1'b0, addr: a, wdata: 16'h0}; exp_q.push_back(x);
          x = '{rd: 1'b0, wr: 1'b1, addr: p, wdata: d}; exp_q.push_back(x);
          ref_mem[p] = d; exp_lat = 3;
        end
        default: exp_err = 1'b1;
      endcase
      do_op(o, a, d, lat, e);
      n_tests++;
      if (lat !== exp_lat || e !== exp_err) begin
        n_fail++; $display("FAIL rand_done[%0d] op=%0d: got lat=%0d err=%b required lat=%0d err=%b",
          k, o, lat, e, exp_lat, exp_err);
      end
      n_tests++;
      if (acc_log.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand_acc_count[%0d] op=%0d: got %0d required %0d",
          k, o, acc_log.size(), exp_q.size());
      end else begin
        foreach (exp_q[j]) begin
          if (acc_log[j].rd !== exp_q[j].rd || acc_log[j].wr !== exp_q[j].wr ||
              acc_log[j].addr !== exp_q[j].addr ||
              (exp_q[j].wr && acc_log[j].wdata !== exp_q[j].wdata)) begin
            n_fail++; $display("FAIL rand_acc[%0d.%0d] op=%0d: got rd=%b wr=%b a=%h d=%h required rd=%b wr=%b a=%h d=%h",
              k, j, o, acc_log[j].rd, acc_log[j].wr, acc_log[j].addr, acc_log[j].wdata,
              exp_q[j].rd, exp_q[j].wr, exp_q[j].addr, exp_q[j].wdata);
          end
        end
      end
      n_tests++;
      if (bus.load_data !== exp_ld || bus.cc !== exp_cc) begin
        n_fail++; $display("FAIL rand_result[%0d] op=%0d: got ld=%h cc=%b required ld=%h cc=%b",
          k, o, bus.load_data, bus.cc, exp_ld, exp_cc);
      end
    end
  endtask

  task automatic test_ld();
    int lat; logic e;
    preload(16'h300D, 16'd10);
    preload(16'h300C, 16'h0000);
    do_op(MEM_LD, 16'h300D, 16'h0, lat, e);
    n_tests++;
    if (lat != 2 || bus.load_data !== 16'h000A || bus.cc !== 3'b001) begin
      n_fail++; $display("FAIL ld: got lat=%0d ld=%h cc=%b required lat=2 ld=000a cc=001",
        lat, bus.load_data, bus.cc);
    end
    n_tests++;
    if (acc_log.size() != 1 || acc_log[0].rd !== 1'b1 || acc_log[0].addr !== 16'h300D) begin
      n_fail++; $display("FAIL ld_access: got %0d accesses required one read of 300d", acc_log.size());
    end
  endtask

  task automatic test_st_ld();
    int lat; logic e;
    do_op(MEM_ST, 16'h300C, 16'hFFFB, lat, e);
    n_tests++;
    if (lat != 2 || bus.cc !== 3'b001 || bus.load_data !== 16'h000A) begin
      n_fail++; $display("FAIL st: got lat=%0d ld=%h cc=%b required lat=2 ld=000a cc=001",
        lat, bus.load_data, bus.cc);
    end
    n_tests++;
    if (acc_log.size() != 1 || acc_log[0].wr !== 1'b1 || acc_log[0].addr !== 16'h300C ||
        acc_log[0].wdata !== 16'hFFFB) begin
      n_fail++; $display("FAIL st_access: got %0d accesses required one write fffb to 300c", acc_log.size());
    end
    do_op(MEM_LD, 16'h300C, 16'h0, lat, e);
    n_tests++;
    if (bus.load_data !== 16'hFFFB || bus.cc !== 3'b100) begin
      n_fail++; $display("FAIL st_readback: got ld=%h cc=%b required ld=fffb cc=100",
        bus.load_data, bus.cc);
    end
  endtask

  task automatic test_ldi();
    int lat; logic e;
    preload(16'h4000, 16'h300D);
    do_op(MEM_LDI, 16'h4000, 16'h0, lat, e);
    n_tests++;
    if (lat != 3 || bus.load_data !== 16'h000A || bus.cc !== 3'b001) begin
      n_fail++; $display("FAIL ldi: got lat=%0d ld=%h cc=%b required lat=3 ld=000a cc=001",
        lat, bus.load_data, bus.cc);
    end
    n_tests++;
    if (acc_log.size() != 2 || acc_log[0].addr !== 16'h4000 || acc_log[1].addr !== 16'h300D ||
        acc_log[0].rd !== 1'b1 || acc_log[1].rd !== 1'b1) begin
      n_fail++; $display("FAIL ldi_access: got %0d accesses required reads of 4000 then 300d", acc_log.size());
    end
  endtask

  task automatic test_sti();
    int lat; logic e; int nwr;
    preload(16'h4001, 16'h300C);
    do_op(MEM_STI, 16'h4001, 16'h0000, lat, e);
    nwr = 0;
    foreach (acc_log[j]) if (acc_log[j].wr) nwr++;
    n_tests++;
    if (lat != 3 || nwr != 1 || acc_log.size() != 2 || acc_log[1].addr !== 16'h300C ||
        acc_log[1].wdata !== 16'h0000) begin
      n_fail++; $display("FAIL sti: got lat=%0d writes=%0d accesses=%0d required lat=3 one write 0000 to 300c",
        lat, nwr, acc_log.size());
    end
    do_op(MEM_LD, 16'h300C, 16'h0, lat, e);
    n_tests++;
    if (bus.load_data !== 16'h0000 || bus.cc !== 3'b010) begin
      n_fail++; $display("FAIL sti_readback: got ld=%h cc=%b required ld=0000 cc=010",
        bus.load_data, bus.cc);
    end
  endtask

  task automatic test_sti_reset();
    int nwr;
    preload(16'h300C, 16'h1234);
    acc_log.delete(); done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MEM_STI; bus.ea = 16'h4001; bus.st_data = 16'h5555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL sti_reset_busy: got %b required 0", bus.busy);
    end
    repeat (4) @(negedge clk);
    nwr = 0;
    foreach (acc_log[j]) if (acc_log[j].wr) nwr++;
    n_tests++;
    if (nwr != 0 || mem[16'h300C] !== 16'h1234 || done_cnt != 0) begin
      n_fail++; $display("FAIL sti_reset_abort: got writes=%0d M=%h dones=%0d required 0/1234/0",
        nwr, mem[16'h300C], done_cnt);
    end
    n_tests++;
    if (bus.load_data !== 16'h0 || bus.cc !== 3'b010) begin
      n_fail++; $display("FAIL sti_reset_regs: got ld=%h cc=%b required ld=0000 cc=010",
        bus.load_data, bus.cc);
    end
  endtask

  task automatic test_illegal();
    logic d_seen, e_seen;
    acc_log.delete(); done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.ea = 16'h300D; bus.st_data = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MEM_LD;
    @(posedge clk); #1;
    @(negedge clk);
    d_seen = bus.done; e_seen = bus.err;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (d_seen !== 1'b1 || e_seen !== 1'b1) begin
      n_fail++; $display("FAIL illegal_done: got done=%b err=%b at start+2 required 1/1", d_seen, e_seen);
    end
    n_tests++;
    if (done_cnt != 1 || acc_log.size() != 0) begin
      n_fail++; $display("FAIL illegal_ignore: got dones=%0d accesses=%0d required 1/0", done_cnt, acc_log.size());
    end
    n_tests++;
    if (bus.load_data !== 16'h0 || bus.cc !== 3'b010) begin
      n_fail++; $display("FAIL illegal_regs: got ld=%h cc=%b required ld=0000 cc=010",
        bus.load_data, bus.cc);
    end
  endtask

  task automatic test_back_to_back();
    acc_log.delete(); done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MEM_LD; bus.ea = 16'h300D; bus.st_data = 16'h0;
    repeat (7) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (done_cnt != 3 || acc_log.size() != 3 || bus.load_data !== 16'h000A) begin
      n_fail++; $display("FAIL back_to_back: got dones=%0d reads=%0d ld=%h required 3/3/000a",
        done_cnt, acc_log.size(), bus.load_data);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.ea = '0; bus.st_data = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_random();
    test_ld();
    test_st_ld();
    test_ldi();
    test_sti();
    test_sti_reset();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lc3_mem_stage
`default_nettype wire
